// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b - borrow_in over WIDTH bits, DIGIT bits
// per clock, LSB slice first, with a start/done handshake and status flags.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  // state | meaning
  // IDLE  | waiting for start, operands not yet latched
  // RUN   | one DIGIT-bit slice processed per edge
  // DONE  | one-cycle completion pulse, results already updated

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DIGIT + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] res_shift;

  // Slice datapath: DIGIT+1 bit subtract, MSB is the outgoing borrow; the
  // new digit enters the result register from the MSB side.
  always_comb begin
    slice     = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]} - SW'(borrow_q);
    res_shift = (res_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    zero_d       = zero_q;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = borrow_in;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          res_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        res_d    = res_shift;
        borrow_d = slice[DIGIT];
        a_sh_d   = a_sh_q >> DIGIT;
        b_sh_d   = b_sh_q >> DIGIT;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          diff_d       = res_shift;
          borrow_out_d = slice[DIGIT];
          overflow_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          zero_d       = (res_shift == '0);
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
      zero_q       <= zero_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor computing `diff = a - b - borrow_in` over WIDTH bits, one DIGIT-bit slice per clock, LSB slice first, with the borrow carried in a register between slices. It is the sequential successor to the single-bit full subtractor in the arithmetic library. It trades latency for a DIGIT-bit-wide subtract datapath, and adds a start/done handshake plus signed-overflow and zero status flags. It sits between operand registers and any consumer that can tolerate WIDTH/DIGIT cycles of latency.

## Interface
- WIDTH, 16, operand and result width in bits; must be a positive multiple of DIGIT.
- DIGIT, 4, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH; N = WIDTH/DIGIT slices.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; accepted only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- borrow_in  input  1  initial borrow; sampled with a and b.
- busy  output  1  high while slices are being computed (RUN state).
- done  output  1  one-cycle pulse when the result registers are updated (DONE state).
- diff  output  WIDTH  result a - b - borrow_in, modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff unsigned a < b + borrow_in.
- overflow  output  1  two's-complement overflow of the subtraction.
- zero  output  1  1 iff diff == 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: when start = 1, load a, b and borrow_in into internal shift registers, clear the slice counter, and go to RUN. Otherwise stay in IDLE.
- RUN: each edge does the following:
  - Compute the low DIGIT bits of a_sh − b_sh − borrow_reg.
  - Shift those bits into the result register from the MSB side.
  - Update borrow_reg with the slice borrow.
  - Shift a_sh and b_sh right by DIGIT and increment the counter.
- RUN exit: on the edge that processes slice N−1, go to DONE.
- RUN to DONE update: on that same edge, write diff, borrow_out, overflow and zero.
- DONE: go to IDLE unconditionally on the next edge.
- start in RUN or DONE is ignored and is not queued. Operands presented then have no effect.
- Flag rules, evaluated on the final WIDTH-bit result:
  - overflow = (a[WIDTH−1] ≠ b[WIDTH−1]) and (diff[WIDTH−1] ≠ a[WIDTH−1]), using the latched a and b. borrow_in takes part through diff.
  - zero = (diff == 0).
- diff, borrow_out, overflow and zero hold their values until the next completion. They do not change during a later RUN.
- Slice arithmetic is DIGIT+1 bits wide. The MSB of the slice result is the outgoing borrow.
- N = 1 (DIGIT = WIDTH) is legal: RUN lasts one cycle.

## Timing
- Reset (rst = 1 at an edge): state IDLE, busy = 0, done = 0, diff = 0, borrow_out = 0, overflow = 0, zero = 0, internal registers cleared.
- Reset in RUN or DONE aborts the operation. No done pulse follows, and the outputs take their reset values.
- rst has priority over start in the same cycle.
- Start accepted at edge k:
  - busy = 1 during the N cycles following edges k … k+N−1.
  - done = 1 during the single cycle following edge k+N; busy = 0 in that cycle.
  - Result outputs are valid from edge k+N.
- Latency from the start edge to done is N cycles. The earliest next accepting edge is k+N+2, giving a throughput of one operation per N+2 cycles.
- busy and done are never high together, and both are 0 in IDLE.

## Test plan
- WIDTH = 16, DIGIT = 4: a = 0x1234, b = 0x0234, borrow_in = 0 → diff = 0x1000, borrow_out = 0, overflow = 0, zero = 0. busy is high for exactly 4 cycles and done pulses for 1 cycle, 4 edges after start.
- a = 0x0000, b = 0x0001, borrow_in = 0 → diff = 0xFFFF, borrow_out = 1, overflow = 0, zero = 0.
- a = 0x8000, b = 0x0001, borrow_in = 0 → diff = 0x7FFF, borrow_out = 0, overflow = 1. Also a = 0x5555, b = 0x5554, borrow_in = 1 → diff = 0x0000, zero = 1, borrow_out = 0.
- start pulsed again during RUN with a = 0xFFFF, b = 0x0000 → ignored; the first operation's result is reported and there is exactly one done pulse.
- rst asserted in the 2nd RUN cycle → no done pulse and all outputs 0 next cycle. A new start then completes normally: a = 0x0003, b = 0x0005 → diff = 0xFFFE, borrow_out = 1.
- Parameter sweep DIGIT ∈ {1, 4, 16} with WIDTH = 16 and 1000 random operand sets: results match the golden model (a − b − borrow_in) and the latency equals WIDTH/DIGIT cycles in every configuration.
